// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] ra, rb;
  logic            borrow;
  logic [CW-1:0]   cnt;
  logic            x, y, d, br_next, last, accept;

  always_comb begin
    x          = ra[0];
    y          = rb[0];
    d          = x ^ y ^ borrow;
    br_next    = (~x & y) | (~(x ^ y) & borrow);
    last       = (cnt == CW'(WIDTH - 1));
    accept     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ra     <= a;
        rb     <= b;
        borrow <= 1'b0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        ra     <= ra >> 1;
        rb     <= rb >> 1;
        // New result bit enters at the MSB; after WIDTH shifts diff is LSB-aligned.
        diff   <= (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
        borrow <= br_next;
        cnt    <= cnt + CW'(1);
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          bout <= br_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int n_checks = 0;
  int n_pass   = 0;
  logic running = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // done and busy must never be high together
  always @(negedge clk) begin
    if (running) begin
      chk("excl8", {31'b0, busy & done}, 32'd0);
      chk("excl1", {31'b0, busy1 & done1}, 32'd0);
    end
  end

  // Called at the negedge just after the accepting edge; returns at the done negedge.
  task automatic wait_result(input string tag, input logic [7:0] exp_diff, input logic exp_bout);
    int cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_busycyc"}, cyc, 8);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_diff"}, {24'b0, diff}, {24'b0, exp_diff});
    chk({tag, "_bout"}, {31'b0, bout}, {31'b0, exp_bout});
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] exp_diff, input logic exp_bout);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(tag, exp_diff, exp_bout);
    @(negedge clk);
    chk({tag, "_donedrop"}, {31'b0, done}, 32'd0);
    chk({tag, "_hold"}, {23'b0, bout, diff}, {23'b0, exp_bout, exp_diff});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] model;
    int dcount;

    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_diff", {24'b0, diff}, 32'd0);
    chk("rst_bout", {31'b0, bout}, 32'd0);
    chk("rst_w1", {28'b0, busy1, done1, diff1, bout1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic vectors
    run_op("t1", 8'h5A, 8'h23, 8'h37, 1'b0);
    run_op("t2a", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("t2b", 8'h10, 8'h20, 8'hF0, 1'b1);
    run_op("t2c", 8'hFF, 8'hFF, 8'h00, 1'b0);

    // start held high during busy with different operands: ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h23; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("t3a_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("t3a_done", {31'b0, done}, 32'd1);
    chk("t3a_diff", {24'b0, diff}, 32'h37);
    chk("t3a_bout", {31'b0, bout}, 32'd0);
    @(negedge clk);

    // Back-to-back: start in the done cycle
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("t3b1", 8'hF0, 1'b1);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3b_busyrise", {31'b0, busy}, 32'd1);
    chk("t3b_donefall", {31'b0, done}, 32'd0);
    wait_result("t3b2", 8'h22, 1'b0);
    @(negedge clk);

    // Async reset at the 4th RUN cycle
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd0);
    chk("t4_diff", {24'b0, diff}, 32'd0);
    chk("t4_bout", {31'b0, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("t4_nodone", dcount, 0);
    run_op("t4_after", 8'h80, 8'h01, 8'h7F, 1'b0);

    // Pseudo-random back-to-back pairs
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom);
    a = ra; b = rb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      model = {1'b0, ra} - {1'b0, rb};
      wait_result("t5", model[7:0], model[8]);
      if (i < 39) begin
        ra = 8'($urandom); rb = 8'($urandom);
        a = ra; b = rb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(negedge clk);

    // WIDTH=1 instance
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t6_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    chk("t6_done", {31'b0, done1}, 32'd1);
    chk("t6_diff", {31'b0, diff1}, 32'd1);
    chk("t6_bout", {31'b0, bout1}, 32'd1);
    a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t6b_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    chk("t6b_done", {31'b0, done1}, 32'd1);
    chk("t6b_diff", {31'b0, diff1}, 32'd1);
    chk("t6b_bout", {31'b0, bout1}, 32'd0);
    @(negedge clk);
    chk("t6b_donedrop", {31'b0, done1}, 32'd0);

    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
